// File: rtl/timer4_ctrl_if.sv
// ---------------------------------------------------------------------------
// timer4_ctrl_if
//   Command channel between a host command source and timer4_ctrl.
//   Ports (signals):
//     valid  host -> ctrl  command present
//     ready  ctrl -> host  controller can accept a command
//     op     host -> ctrl  opcode: 00 NOP, 01 LOAD, 10 START one-shot,
//                          11 START periodic
//     data   host -> ctrl  period value carried by LOAD
//   Modports: master (host side), slave (controller side).
// ---------------------------------------------------------------------------
interface timer4_ctrl_if #(
  parameter int WIDTH = 4
) ();
  logic             valid;
  logic             ready;
  logic [1:0]       op;
  logic [WIDTH-1:0] data;

  modport master (output valid, output op, output data, input ready);
  modport slave  (input valid, input op, input data, output ready);
endinterface

// File: rtl/timer4_ctrl.sv
// ---------------------------------------------------------------------------
// timer4_ctrl
//   Sequencing controller for a 4-bit counter datapath. Accepts LOAD/START
//   commands over a valid/ready channel, gates counter increments through
//   an optional prescaler, flags terminal count, and runs either one-shot
//   or auto-reload (periodic).
//
//   Build option: define TIMER4_CTRL_PRESCALE_EN to include the prescaler.
//   Without it the pre/DIVR registers are absent, div is ignored and the
//   counter ticks on every RUN cycle.
//
//   Ports:
//     clk     in   rising-edge clock
//     resetn  in   synchronous active-low reset
//     cmd     slave modport of timer4_ctrl_if (valid/ready/op/data)
//     div     in   prescale divisor, captured on START
//     stop    in   level abort back to IDLE
//     tick    out  increment strobe to the counter datapath
//     o       out  current count
//     cout    out  one-cycle terminal-count pulse
//     busy    out  high while running
//     done    out  high once a one-shot run has completed
// ---------------------------------------------------------------------------
module timer4_ctrl #(
  parameter int WIDTH = 4,
  parameter int PRE_W = 8
) (
  input  logic             clk,
  input  logic             resetn,
  timer4_ctrl_if.slave     cmd,
  input  logic [PRE_W-1:0] div,
  input  logic             stop,
  output logic             tick,
  output logic [WIDTH-1:0] o,
  output logic             cout,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [1:0] OP_LOAD     = 2'b01;
  localparam logic [1:0] OP_ONESHOT  = 2'b10;
  localparam logic [1:0] OP_PERIODIC = 2'b11;

  state_t           state;
  logic [WIDTH-1:0] period;
  logic             mode;
  logic             ready_r;
  logic             busy_r;
  logic             done_r;
  logic             accept;
  logic             terminal;

`ifdef TIMER4_CTRL_PRESCALE_EN
  logic [PRE_W-1:0] divr;
  logic [PRE_W-1:0] pre;

  // The prescaler counts 0..DIVR; the counter advances on the wrap cycle.
  assign tick = (state == S_RUN) && (pre == divr);
`else
  logic unused_div;

  assign unused_div = ^div;
  assign tick       = (state == S_RUN);
`endif

  assign accept   = cmd.valid && ready_r;
  assign terminal = tick && (o == period);

  // A same-cycle abort or reset swallows the terminal-count pulse.
  assign cout = terminal && !stop && resetn;

  assign cmd.ready = ready_r;
  assign busy      = busy_r;
  assign done      = done_r;

  // Single FSM: state, datapath registers and the registered status flags
  // (ready/busy/done) all move together so the flags always match state.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state   <= S_IDLE;
      period  <= '0;
      mode    <= 1'b0;
      o       <= '0;
      ready_r <= 1'b1;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
`ifdef TIMER4_CTRL_PRESCALE_EN
      pre     <= '0;
      divr    <= '0;
`endif
    end else begin
      case (state)
        S_RUN: begin
          if (stop) begin
            state   <= S_IDLE;
            o       <= '0;
            ready_r <= 1'b1;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
`ifdef TIMER4_CTRL_PRESCALE_EN
            pre     <= '0;
`endif
          end else if (tick) begin
`ifdef TIMER4_CTRL_PRESCALE_EN
            pre <= '0;
`endif
            if (o == period) begin
              // Periodic reloads from zero; one-shot parks at PERIOD.
              if (mode) begin
                o <= '0;
              end else begin
                state   <= S_DONE;
                ready_r <= 1'b1;
                busy_r  <= 1'b0;
                done_r  <= 1'b1;
              end
            end else begin
              o <= o + 1'b1;
            end
          end
`ifdef TIMER4_CTRL_PRESCALE_EN
          else begin
            pre <= pre + 1'b1;
          end
`endif
        end

        default: begin
          // IDLE and DONE accept commands; abort only matters from DONE.
          if (stop && (state == S_DONE)) begin
            state   <= S_IDLE;
            o       <= '0;
            ready_r <= 1'b1;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
`ifdef TIMER4_CTRL_PRESCALE_EN
            pre     <= '0;
`endif
          end else if (accept) begin
            case (cmd.op)
              OP_LOAD: begin
                period <= cmd.data;
              end
              OP_ONESHOT, OP_PERIODIC: begin
                state   <= S_RUN;
                mode    <= cmd.op[0];
                o       <= '0;
                ready_r <= 1'b0;
                busy_r  <= 1'b1;
                done_r  <= 1'b0;
`ifdef TIMER4_CTRL_PRESCALE_EN
                pre     <= '0;
                divr    <= div;
`endif
              end
              default: begin
              end
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_timer4_ctrl.sv
// ---------------------------------------------------------------------------
// tb_timer4_ctrl
//   Self-checking bench for timer4_ctrl. Inputs are driven 1 ns after the
//   rising edge and outputs are sampled 2 ns after it. Expected behaviour is
//   computed from elapsed RUN cycles with plain arithmetic.
//   Observed vector layout: {o[3:0], cout, tick, busy, done, ready}.
// ---------------------------------------------------------------------------
module tb_timer4_ctrl;
  localparam int WIDTH = 4;
  localparam int PRE_W = 8;
  localparam logic [8:0] IDLE_VEC = 9'b0000_0000_1;

  logic             clk = 1'b0;
  logic             resetn = 1'b0;
  logic [PRE_W-1:0] div = '0;
  logic             stop = 1'b0;
  logic             tick;
  logic [WIDTH-1:0] o;
  logic             cout;
  logic             busy;
  logic             done;

  int total = 0;
  int bad   = 0;

  timer4_ctrl_if #(.WIDTH(WIDTH)) cmd_bus ();

  timer4_ctrl #(.WIDTH(WIDTH), .PRE_W(PRE_W)) dut (
    .clk    (clk),
    .resetn (resetn),
    .cmd    (cmd_bus),
    .div    (div),
    .stop   (stop),
    .tick   (tick),
    .o      (o),
    .cout   (cout),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  // Divisor the hardware actually applies in this build.
  function automatic int eff(int d);
`ifdef TIMER4_CTRL_PRESCALE_EN
    return d;
`else
    return 0;
`endif
  endfunction

  // Expected outputs t cycles after a START accepted with period p and
  // effective divisor d: one tick per (d+1) cycles, (p+1) ticks per period.
  function automatic logic [8:0] model(int p, int d, bit periodic, int t);
    int per;
    int k;
    bit tk;
    logic [3:0] ov;
    per = d + 1;
    k   = t / per;
    tk  = ((t % per) == d);
    if (periodic) begin
      ov = 4'(k % (p + 1));
      return {ov, tk && ((k % (p + 1)) == p), tk, 1'b1, 1'b0, 1'b0};
    end else if (t < (p + 1) * per) begin
      ov = 4'(k);
      return {ov, tk && (k == p), tk, 1'b1, 1'b0, 1'b0};
    end else begin
      ov = 4'(p);
      return {ov, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    end
  endfunction

  function automatic logic [8:0] observed();
    return {o, cout, tick, busy, done, cmd_bus.ready};
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #2;
  endtask

  // Issues one command from a sample point; returns at the sample point of
  // the cycle following acceptance.
  task automatic send_cmd(input logic [1:0] op, input int data, input int dv);
    cmd_bus.valid = 1'b1;
    cmd_bus.op    = op;
    cmd_bus.data  = 4'(data);
    div           = 8'(dv);
    @(posedge clk);
    #1;
    cmd_bus.valid = 1'b0;
    cmd_bus.op    = 2'b00;
    #1;
  endtask

  task automatic test_reset();
    logic [8:0] exp;
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    #1;
    total++; if (o !== 4'd0) begin bad++; $display("[TB] FAIL reset_o got=%0d exp=0", o); end
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy got=%b exp=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("[TB] FAIL reset_done got=%b exp=0", done); end
    total++; if (cout !== 1'b0) begin bad++; $display("[TB] FAIL reset_cout got=%b exp=0", cout); end
    total++; if (cmd_bus.ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_ready got=%b exp=1", cmd_bus.ready); end
    // PERIOD resets to 0, so a one-shot finishes on its first tick.
    send_cmd(2'b10, 0, 0);
    for (int t = 0; t <= 2; t++) begin
      if (t > 0) next_cycle();
      exp = model(0, 0, 1'b0, t);
      total++;
      if (observed() !== exp) begin
        bad++; $display("[TB] FAIL reset_period0 t=%0d got=%b exp=%b", t, observed(), exp);
      end
    end
  endtask

  task automatic test_oneshot();
    logic [8:0] exp;
    int p;
    int dv;
    int d;
    for (int i = 0; i < 5; i++) begin
      p  = (i == 0) ? 3 : $urandom_range(0, 15);
      dv = (i == 0) ? 0 : $urandom_range(0, 3);
      d  = eff(dv);
      if (i == 2) send_cmd(2'b00, 9, 0);
      send_cmd(2'b01, p, 0);
      send_cmd(2'b10, 0, dv);
      for (int t = 0; t <= (p + 1) * (d + 1) + 1; t++) begin
        if (t > 0) next_cycle();
        exp = model(p, d, 1'b0, t);
        total++;
        if (observed() !== exp) begin
          bad++; $display("[TB] FAIL oneshot p=%0d d=%0d t=%0d got=%b exp=%b", p, d, t, observed(), exp);
        end
      end
    end
  endtask

  task automatic test_periodic();
    logic [8:0] exp;
    int p;
    int dv;
    int d;
    for (int i = 0; i < 5; i++) begin
      p  = (i == 0) ? 2 : (i == 1) ? 15 : $urandom_range(0, 6);
      dv = (i == 0) ? 1 : (i == 1) ? 0 : $urandom_range(0, 3);
      d  = eff(dv);
      send_cmd(2'b01, p, 0);
      send_cmd(2'b11, 0, dv);
      for (int t = 0; t <= 2 * (p + 1) * (d + 1) + 1; t++) begin
        if (t > 0) next_cycle();
        exp = model(p, d, 1'b1, t);
        total++;
        if (observed() !== exp) begin
          bad++; $display("[TB] FAIL periodic p=%0d d=%0d t=%0d got=%b exp=%b", p, d, t, observed(), exp);
        end
      end
      stop = 1'b1;
      next_cycle();
      stop = 1'b0;
      total++;
      if (observed() !== IDLE_VEC) begin
        bad++; $display("[TB] FAIL periodic_stop got=%b exp=%b", observed(), IDLE_VEC);
      end
    end
  endtask

  task automatic test_stop_collision();
    logic [8:0] exp;
    int p;
    int d;
    int tt;
    for (int i = 0; i < 3; i++) begin
      p  = $urandom_range(1, 5);
      d  = eff($urandom_range(0, 2));
      tt = (p + 1) * (d + 1) - 1;
      send_cmd(2'b01, p, 0);
      send_cmd(2'b11, 0, d);
      for (int t = 1; t <= tt; t++) next_cycle();
      stop = 1'b1;
      #1;
      exp = model(p, d, 1'b1, tt);
      exp[4] = 1'b0;
      total++;
      if (observed() !== exp) begin
        bad++; $display("[TB] FAIL stop_collision p=%0d d=%0d got=%b exp=%b", p, d, observed(), exp);
      end
      next_cycle();
      stop = 1'b0;
      total++;
      if (observed() !== IDLE_VEC) begin
        bad++; $display("[TB] FAIL stop_collision_idle got=%b exp=%b", observed(), IDLE_VEC);
      end
    end
  endtask

  task automatic test_handshake();
    logic [8:0] exp;
    int p;
    int p2;
    int d;
    int d2;
    int dv2;
    p   = $urandom_range(1, 4);
    d   = eff($urandom_range(0, 2));
    dv2 = $urandom_range(0, 2);
    d2  = eff(dv2);
    send_cmd(2'b01, p, 0);
    send_cmd(2'b10, 0, d);
    // Hold a periodic START (with a new divisor) throughout the run.
    cmd_bus.valid = 1'b1;
    cmd_bus.op    = 2'b11;
    div           = 8'(dv2);
    for (int t = 0; t <= (p + 1) * (d + 1); t++) begin
      if (t > 0) next_cycle();
      exp = model(p, d, 1'b0, t);
      total++;
      if (observed() !== exp) begin
        bad++; $display("[TB] FAIL hs_held t=%0d got=%b exp=%b", t, observed(), exp);
      end
    end
    next_cycle();
    cmd_bus.valid = 1'b0;
    cmd_bus.op    = 2'b00;
    for (int t = 0; t <= (p + 1) * (d2 + 1) + 1; t++) begin
      if (t > 0) next_cycle();
      exp = model(p, d2, 1'b1, t);
      total++;
      if (observed() !== exp) begin
        bad++; $display("[TB] FAIL hs_accepted t=%0d got=%b exp=%b", t, observed(), exp);
      end
    end
    stop = 1'b1;
    next_cycle();
    stop = 1'b0;
    // LOAD while DONE keeps DONE and changes the next run's period.
    p2 = $urandom_range(5, 9);
    send_cmd(2'b10, 0, 0);
    for (int t = 1; t <= p + 1; t++) next_cycle();
    send_cmd(2'b01, p2, 0);
    exp = model(p, 0, 1'b0, p + 2);
    total++;
    if (observed() !== exp) begin
      bad++; $display("[TB] FAIL hs_load_in_done got=%b exp=%b", observed(), exp);
    end
    send_cmd(2'b10, 0, 0);
    for (int t = 0; t <= p2 + 1; t++) begin
      if (t > 0) next_cycle();
      exp = model(p2, 0, 1'b0, t);
      total++;
      if (observed() !== exp) begin
        bad++; $display("[TB] FAIL hs_new_period t=%0d got=%b exp=%b", t, observed(), exp);
      end
    end
  endtask

  task automatic test_reset_midrun();
    logic [8:0] exp;
    int p;
    int d;
    int tt;
    p  = $urandom_range(1, 4);
    d  = eff($urandom_range(0, 2));
    tt = (p + 1) * (d + 1) - 1;
    send_cmd(2'b01, p, 0);
    send_cmd(2'b11, 0, d);
    for (int t = 1; t <= tt; t++) next_cycle();
    resetn = 1'b0;
    #1;
    total++;
    if (cout !== 1'b0) begin
      bad++; $display("[TB] FAIL reset_mid_cout got=%b exp=0", cout);
    end
    @(posedge clk);
    #1 resetn = 1'b1;
    #1;
    total++;
    if (observed() !== IDLE_VEC) begin
      bad++; $display("[TB] FAIL reset_mid_idle got=%b exp=%b", observed(), IDLE_VEC);
    end
    send_cmd(2'b10, 0, 0);
    for (int t = 0; t <= 1; t++) begin
      if (t > 0) next_cycle();
      exp = model(0, 0, 1'b0, t);
      total++;
      if (observed() !== exp) begin
        bad++; $display("[TB] FAIL reset_mid_period0 t=%0d got=%b exp=%b", t, observed(), exp);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [8:0] exp;
    bit per_mode;
    int p;
    int d;
    int n;
    for (int i = 0; i < 8; i++) begin
      per_mode = 1'($urandom_range(0, 1));
      p = $urandom_range(0, 15);
      d = $urandom_range(0, 3);
      n = $urandom_range(1, 40);
      send_cmd(2'b01, p, 0);
      send_cmd(per_mode ? 2'b11 : 2'b10, 0, d);
      d = eff(d);
      for (int t = 0; t < n; t++) begin
        if (t > 0) next_cycle();
        exp = model(p, d, per_mode, t);
        total++;
        if (observed() !== exp) begin
          bad++; $display("[TB] FAIL b2b i=%0d p=%0d d=%0d t=%0d got=%b exp=%b", i, p, d, t, observed(), exp);
        end
      end
      if ($urandom_range(0, 1) == 1) begin
        stop = 1'b1;
        next_cycle();
        stop = 1'b0;
        total++;
        if (observed() !== IDLE_VEC) begin
          bad++; $display("[TB] FAIL b2b_stop i=%0d got=%b exp=%b", i, observed(), IDLE_VEC);
        end
      end else if (per_mode || (n <= (p + 1) * (d + 1))) begin
        stop = 1'b1;
        next_cycle();
        stop = 1'b0;
      end
    end
  endtask

  initial begin
    cmd_bus.valid = 1'b0;
    cmd_bus.op    = 2'b00;
    cmd_bus.data  = '0;
    test_reset();
    test_oneshot();
    test_periodic();
    test_stop_collision();
    test_handshake();
    test_reset_midrun();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
